// File: rtl/z80_timer_intc.sv
// Down-counting timer with maskable interrupt and vectored acknowledge on the z80 I/O bus.
// Register reads are combinational; writes land on the first strobe cycle; INT_L is one cycle behind PEND.
module z80_timer_intc #(
  parameter logic [7:0] BASE_PORT = 8'h40,
  parameter int         PRESCALE  = 16,
  parameter logic [7:0] VECTOR    = 8'hE0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_out,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic        M1_L,
  output logic [7:0]  data_in,
  output logic        data_oe,
  output logic        INT_L
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR_HOLD, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [7:0]    reload_q, reload_d;
  logic [7:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          pend_q, pend_d;
  logic [7:0]    vec_q, vec_d;
  logic          int_l_q, int_l_d;

  logic [7:0] off;
  logic       sel;
  logic       ack_cyc;
  logic       wr_fire;
  logic       ack_clr;
  logic       tick;
  logic       expire;
  logic [7:0] rd_dat;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^addr_bus[15:8];

  // Offset wraps below BASE_PORT, so a single compare covers both window edges.
  assign off     = addr_bus[7:0] - BASE_PORT;
  assign sel     = ~IORQ_L & M1_L & (off <= 8'd4);
  assign ack_cyc = ~IORQ_L & (~M1_L | (state_q == S_ACK));

  // Bus FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Bus FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sel && !WR_L)           state_d = S_WR_HOLD;
        else if (!M1_L && !IORQ_L)  state_d = S_ACK;
      end
      S_WR_HOLD: if (IORQ_L || WR_L) state_d = S_IDLE;
      S_ACK:     if (IORQ_L)         state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Bus FSM: outputs (one write per strobe, ack clear on IORQ release)
  always_comb begin
    wr_fire = (state_q == S_IDLE) && sel && !WR_L;
    ack_clr = (state_q == S_ACK) && IORQ_L;
  end

  assign tick   = ctrl_q[0] && (presc_q == PRESC_MAX);
  assign expire = tick && (count_q == 8'd1);

  always_comb begin
    presc_d  = '0;
    ctrl_d   = ctrl_q;
    reload_d = reload_q;
    count_d  = count_q;
    pend_d   = pend_q;
    vec_d    = vec_q;

    if (ctrl_q[0]) presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;

    if (tick) begin
      if (expire) begin
        count_d = ctrl_q[2] ? reload_q : 8'd0;
        if (!ctrl_q[2]) ctrl_d[0] = 1'b0;
      end else begin
        count_d = count_q - 8'd1;
      end
    end

    if (wr_fire) begin
      case (off)
        8'd0: ctrl_d = data_out[2:0];
        8'd1: begin
          reload_d = data_out;
          count_d  = data_out;
        end
        8'd3: if (data_out[0]) pend_d = 1'b0;
        8'd4: vec_d = data_out;
        default: ;
      endcase
    end

    if (ack_clr) pend_d = 1'b0;
    // A fresh expiry must never be lost to a same-cycle clear.
    if (expire)  pend_d = 1'b1;

    int_l_d = ~(pend_q & ctrl_q[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      pend_q   <= 1'b0;
      vec_q    <= VECTOR;
      int_l_q  <= 1'b1;
    end else begin
      ctrl_q   <= ctrl_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      pend_q   <= pend_d;
      vec_q    <= vec_d;
      int_l_q  <= int_l_d;
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    case (off)
      8'd0:    rd_dat = {5'b0, ctrl_q};
      8'd1:    rd_dat = reload_q;
      8'd2:    rd_dat = count_q;
      8'd3:    rd_dat = {7'b0, pend_q};
      8'd4:    rd_dat = vec_q;
      default: rd_dat = 8'h00;
    endcase
  end

  always_comb begin
    data_oe = 1'b0;
    data_in = 8'h00;
    if (!rst) begin
      if (ack_cyc) begin
        data_oe = 1'b1;
        data_in = vec_q;
      end else if (sel && !RD_L) begin
        data_oe = 1'b1;
        data_in = rd_dat;
      end
    end
  end

  assign INT_L = int_l_q;

endmodule

// File: tb/tb_z80_timer_intc.sv
// Directed bench for z80_timer_intc: register access, timer expiry timing, ack and decode.
module tb_z80_timer_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_bus;
  logic [7:0]  data_out;
  logic        IORQ_L, RD_L, WR_L, M1_L;
  logic [7:0]  data_in;
  logic        data_oe;
  logic        INT_L;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  z80_timer_intc #(.BASE_PORT(8'h40), .PRESCALE(16), .VECTOR(8'hE0)) dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_out(data_out),
    .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L),
    .data_in(data_in), .data_oe(data_oe), .INT_L(INT_L)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] val);
    @(negedge clk);
    addr_bus = {8'hA5, port};
    data_out = val;
    IORQ_L = 1'b0;
    WR_L   = 1'b0;
    @(negedge clk);
    IORQ_L = 1'b1;
    WR_L   = 1'b1;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] d, output logic oe);
    @(negedge clk);
    addr_bus = {8'h5A, port};
    IORQ_L = 1'b0;
    RD_L   = 1'b0;
    #1;
    d  = data_in;
    oe = data_oe;
    #1;
    IORQ_L = 1'b1;
    RD_L   = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] port, input logic [7:0] exp);
    logic [7:0] d;
    logic oe;
    io_read(port, d, oe);
    chk8(tag, d, exp);
  endtask

  task automatic ack_cycle(output logic [7:0] d, output logic oe);
    @(negedge clk);
    addr_bus = 16'h0038;
    M1_L   = 1'b0;
    IORQ_L = 1'b0;
    #1;
    d  = data_in;
    oe = data_oe;
    @(negedge clk);
    M1_L   = 1'b1;
    IORQ_L = 1'b1;
  endtask

  // Returns the cycle count at which INT_L is first seen low, or -1 on timeout.
  task automatic wait_int_low(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (INT_L === 1'b0) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       oe;
    int t_w, t1, t2;

    rst = 1'b1;
    addr_bus = 16'h0000;
    data_out = 8'h00;
    IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1;
    #1;
    chk8("reset_int_l", {7'b0, INT_L}, 8'h01);
    chk8("reset_oe", {7'b0, data_oe}, 8'h00);
    chk8("reset_data_in", data_in, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd_chk("reset_ctrl", 8'h40, 8'h00);
    rd_chk("reset_vec", 8'h44, 8'hE0);

    // Autoreload periodic timer, RELOAD=3 -> 48 clk period
    io_write(8'h41, 8'h03);
    rd_chk("reload_rb", 8'h41, 8'h03);
    io_write(8'h40, 8'h07);
    t_w = cyc;
    wait_int_low(200, t1);
    chk_int("first_expiry_latency", t1 - t_w, 49);
    rd_chk("status_pend", 8'h43, 8'h01);
    rd_chk("count_reloaded", 8'h42, 8'h03);
    io_write(8'h43, 8'h01);
    chk8("int_l_lag_after_clear", {7'b0, INT_L}, 8'h00);
    @(negedge clk);
    chk8("int_l_high_after_clear", {7'b0, INT_L}, 8'h01);
    wait_int_low(200, t2);
    chk_int("expiry_period", t2 - t1, 48);

    // Interrupt acknowledge
    ack_cycle(d, oe);
    chk8("ack_vector", d, 8'hE0);
    chk8("ack_oe", {7'b0, oe}, 8'h01);
    @(negedge clk);
    chk8("ack_int_l_lag", {7'b0, INT_L}, 8'h00);
    @(negedge clk);
    chk8("ack_int_l_high", {7'b0, INT_L}, 8'h01);
    rd_chk("ack_pend_cleared", 8'h43, 8'h00);
    io_write(8'h44, 8'h20);
    ack_cycle(d, oe);
    chk8("ack_vector_new", d, 8'h20);
    io_write(8'h40, 8'h00);
    io_write(8'h43, 8'h01);

    // One-shot
    io_write(8'h41, 8'h02);
    io_write(8'h40, 8'h03);
    t_w = cyc;
    wait_int_low(200, t1);
    chk_int("oneshot_latency", t1 - t_w, 33);
    rd_chk("oneshot_ctrl", 8'h40, 8'h02);
    rd_chk("oneshot_count", 8'h42, 8'h00);
    repeat (40) @(negedge clk);
    rd_chk("oneshot_count_held", 8'h42, 8'h00);
    io_write(8'h40, 8'h00);
    io_write(8'h43, 8'h01);
    rd_chk("oneshot_cleared", 8'h43, 8'h00);

    // Status clear colliding with expiry tick
    io_write(8'h41, 8'h01);
    io_write(8'h40, 8'h05);
    repeat (14) @(negedge clk);
    io_write(8'h43, 8'h01);
    rd_chk("clear_vs_expiry", 8'h43, 8'h01);
    io_write(8'h40, 8'h00);
    io_write(8'h43, 8'h01);

    // Held write strobe: only the first cycle's data lands
    @(negedge clk);
    addr_bus = 16'h0041;
    data_out = 8'h10;
    IORQ_L = 1'b0;
    WR_L   = 1'b0;
    @(negedge clk);
    data_out = 8'h55;
    repeat (4) @(negedge clk);
    IORQ_L = 1'b1;
    WR_L   = 1'b1;
    rd_chk("held_write_reload", 8'h41, 8'h10);
    rd_chk("held_write_count", 8'h42, 8'h10);

    // RELOAD=0 means 256 ticks
    io_write(8'h41, 8'h00);
    io_write(8'h40, 8'h03);
    t_w = cyc;
    wait_int_low(5000, t1);
    chk_int("reload0_latency", t1 - t_w, 4097);
    io_write(8'h40, 8'h00);
    io_write(8'h43, 8'h01);

    // Decode window edges and memory cycles
    io_write(8'h41, 8'h5A);
    io_read(8'h3F, d, oe);
    chk8("in_3f_oe", {7'b0, oe}, 8'h00);
    chk8("in_3f_data", d, 8'h00);
    io_read(8'h45, d, oe);
    chk8("in_45_oe", {7'b0, oe}, 8'h00);
    io_write(8'h3F, 8'hFF);
    io_write(8'h45, 8'hFF);
    io_write(8'h42, 8'h77);
    @(negedge clk);
    addr_bus = 16'h0041;
    data_out = 8'hEE;
    WR_L = 1'b0;
    @(negedge clk);
    WR_L = 1'b1;
    addr_bus = 16'h0044;
    RD_L = 1'b0;
    #1;
    chk8("mem_read_oe", {7'b0, data_oe}, 8'h00);
    RD_L = 1'b1;
    rd_chk("decode_ctrl", 8'h40, 8'h00);
    rd_chk("decode_reload", 8'h41, 8'h5A);
    rd_chk("decode_count", 8'h42, 8'h5A);
    rd_chk("decode_vec", 8'h44, 8'h20);

    // Reset mid-count with a read in progress
    io_write(8'h41, 8'h05);
    io_write(8'h40, 8'h07);
    repeat (100) @(negedge clk);
    chk8("pre_reset_int_l", {7'b0, INT_L}, 8'h00);
    addr_bus = 16'h0042;
    IORQ_L = 1'b0;
    RD_L   = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk8("midrst_int_l", {7'b0, INT_L}, 8'h01);
    chk8("midrst_oe", {7'b0, data_oe}, 8'h00);
    IORQ_L = 1'b1;
    RD_L   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_chk("midrst_count", 8'h42, 8'h00);
    rd_chk("midrst_vec", 8'h44, 8'hE0);
    rd_chk("midrst_status", 8'h43, 8'h00);

    // Write strobe held across reset release is captured once afterwards
    @(negedge clk);
    rst = 1'b1;
    addr_bus = 16'h0044;
    data_out = 8'h33;
    IORQ_L = 1'b0;
    WR_L   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    IORQ_L = 1'b1;
    WR_L   = 1'b1;
    rd_chk("write_after_reset", 8'h44, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
